// File: rtl/rolling_key_cipher.sv
// Streaming XOR cipher: one key word, then data words XORed with a per-word rotated key,
// with optional ciphertext chaining; results are buffered in a small output FIFO.
module rolling_key_cipher #(
    parameter int DATA_WIDTH = 32,
    parameter int ROT_WIDTH  = 5,
    parameter int ROT_STEP   = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [DATA_WIDTH-1:0]         dataIn,
    input  logic                          rdyIn,
    output logic                          reqIn,
    input  logic [ROT_WIDTH-1:0]          rot_offset,
    input  logic                          prog,
    input  logic                          chain_en,
    input  logic                          decrypt,
    input  logic                          error,
    output logic [DATA_WIDTH-1:0]         dataOut,
    output logic                          reqOut,
    input  logic                          rdyOut,
    output logic [1:0]                    state,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        NO_KEY   = 2'd0,
        LOAD_KEY = 2'd1,
        RUN      = 2'd2
    } state_t;

    function automatic logic [DATA_WIDTH-1:0] rotl(input logic [DATA_WIDTH-1:0] k,
                                                   input logic [ROT_WIDTH-1:0] amt);
        logic [2*DATA_WIDTH-1:0] t;
        t = {k, k} << amt;
        return t[2*DATA_WIDTH-1:DATA_WIDTH];
    endfunction

    state_t                  state_r;
    logic [DATA_WIDTH-1:0]   key_r;
    logic [ROT_WIDTH-1:0]    off_r;
    logic [DATA_WIDTH-1:0]   fb_r;
    logic                    chain_r;
    logic                    decrypt_r;

    logic [DATA_WIDTH-1:0]   mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr_r;
    logic [PTR_W-1:0]        rd_ptr_r;
    logic [CNT_W-1:0]        count_r;
    logic [DATA_WIDTH-1:0]   dataout_r;
    logic                    reqout_r;

    logic                    full_s;
    logic                    reqin_s;
    logic                    xfer_s;
    logic                    push_s;
    logic                    pop_s;
    logic [DATA_WIDTH-1:0]   round_key_s;
    logic [DATA_WIDTH-1:0]   cipher_s;
    logic [PTR_W-1:0]        rd_next_s;
    logic [CNT_W-1:0]        count_next_s;
    logic [DATA_WIDTH-1:0]   head_next_s;

    // Handshake qualification and the cipher datapath for the current word.
    always_comb begin
        full_s = (count_r == CNT_W'(FIFO_DEPTH));
        case (state_r)
            LOAD_KEY: reqin_s = 1'b1;
            RUN:      reqin_s = !full_s;
            default:  reqin_s = 1'b0;
        endcase
        xfer_s      = reqin_s && rdyIn && !error;
        push_s      = xfer_s && (state_r == RUN);
        pop_s       = reqout_r && rdyOut && !error;
        round_key_s = rotl(key_r, off_r);
        if (chain_r) begin
            cipher_s = dataIn ^ round_key_s ^ fb_r;
        end else begin
            cipher_s = dataIn ^ round_key_s;
        end
    end

    // Next FIFO occupancy and next head word, so dataOut can be a plain register.
    always_comb begin
        rd_next_s = rd_ptr_r + PTR_W'(1);
        if (push_s && !pop_s) begin
            count_next_s = count_r + CNT_W'(1);
        end else if (pop_s && !push_s) begin
            count_next_s = count_r - CNT_W'(1);
        end else begin
            count_next_s = count_r;
        end
        if (pop_s) begin
            if (count_r > CNT_W'(1)) begin
                head_next_s = mem_r[rd_next_s];
            end else if (push_s) begin
                head_next_s = cipher_s;
            end else begin
                head_next_s = dataout_r;
            end
        end else if (push_s && (count_r == CNT_W'(0))) begin
            head_next_s = cipher_s;
        end else begin
            head_next_s = dataout_r;
        end
    end

    // Key/mode FSM; the rotation offset advances as a running register per data word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= NO_KEY;
            key_r     <= {DATA_WIDTH{1'b0}};
            off_r     <= {ROT_WIDTH{1'b0}};
            fb_r      <= {DATA_WIDTH{1'b0}};
            chain_r   <= 1'b0;
            decrypt_r <= 1'b0;
        end else if (error) begin
            state_r   <= NO_KEY;
            key_r     <= {DATA_WIDTH{1'b0}};
            off_r     <= {ROT_WIDTH{1'b0}};
            fb_r      <= {DATA_WIDTH{1'b0}};
            chain_r   <= 1'b0;
            decrypt_r <= 1'b0;
        end else begin
            case (state_r)
                NO_KEY: begin
                    if (prog) begin
                        state_r <= LOAD_KEY;
                    end
                end
                LOAD_KEY: begin
                    if (xfer_s) begin
                        key_r     <= dataIn;
                        off_r     <= rot_offset;
                        fb_r      <= {DATA_WIDTH{1'b0}};
                        chain_r   <= chain_en;
                        decrypt_r <= decrypt;
                        if (!prog) begin
                            state_r <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (xfer_s) begin
                        off_r <= off_r + ROT_WIDTH'(ROT_STEP);
                        if (chain_r) begin
                            // Feedback is always the ciphertext side of the transform.
                            fb_r <= decrypt_r ? dataIn : cipher_s;
                        end
                    end
                    if (prog) begin
                        state_r <= LOAD_KEY;
                    end
                end
                default: begin
                    state_r <= NO_KEY;
                end
            endcase
        end
    end

    // Output FIFO storage, pointers, occupancy and registered head/valid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= {DATA_WIDTH{1'b0}};
            end
            wr_ptr_r  <= {PTR_W{1'b0}};
            rd_ptr_r  <= {PTR_W{1'b0}};
            count_r   <= {CNT_W{1'b0}};
            dataout_r <= {DATA_WIDTH{1'b0}};
            reqout_r  <= 1'b0;
        end else if (error) begin
            wr_ptr_r  <= {PTR_W{1'b0}};
            rd_ptr_r  <= {PTR_W{1'b0}};
            count_r   <= {CNT_W{1'b0}};
            dataout_r <= {DATA_WIDTH{1'b0}};
            reqout_r  <= 1'b0;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= cipher_s;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_next_s;
            end
            count_r   <= count_next_s;
            dataout_r <= head_next_s;
            reqout_r  <= (count_next_s != CNT_W'(0));
        end
    end

    assign reqIn      = reqin_s;
    assign dataOut    = dataout_r;
    assign reqOut     = reqout_r;
    assign state      = state_r;
    assign fifo_count = count_r;

endmodule

// File: tb/tb_rolling_key_cipher.sv
// Directed plus randomized bench for rolling_key_cipher against a queue-based reference model.
module tb_rolling_key_cipher;

    localparam int DW    = 32;
    localparam int RW    = 5;
    localparam int STEP  = 1;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] dataIn;
    logic          rdyIn;
    logic          reqIn;
    logic [RW-1:0] rot_offset;
    logic          prog;
    logic          chain_en;
    logic          decrypt;
    logic          error;
    logic [DW-1:0] dataOut;
    logic          reqOut;
    logic          rdyOut;
    logic [1:0]    state;
    logic [2:0]    fifo_count;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [DW-1:0] m_q[$];
    int            m_state;
    logic [DW-1:0] m_key;
    logic [DW-1:0] m_fb;
    int            m_base;
    int            m_n;
    bit            m_chain;
    bit            m_dec;

    rolling_key_cipher #(
        .DATA_WIDTH(DW), .ROT_WIDTH(RW), .ROT_STEP(STEP), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset(reset), .dataIn(dataIn), .rdyIn(rdyIn), .reqIn(reqIn),
        .rot_offset(rot_offset), .prog(prog), .chain_en(chain_en), .decrypt(decrypt),
        .error(error), .dataOut(dataOut), .reqOut(reqOut), .rdyOut(rdyOut),
        .state(state), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] rotl_ref(input logic [DW-1:0] k, input int amt);
        logic [2*DW-1:0] t;
        t = {{DW{1'b0}}, k} << amt;
        return t[DW-1:0] | t[2*DW-1:DW];
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_state = 0;
        m_key   = '0;
        m_fb    = '0;
        m_base  = 0;
        m_n     = 0;
        m_chain = 1'b0;
        m_dec   = 1'b0;
    endtask

    task automatic check_outputs(input string tag);
        bit exp_req;
        exp_req = (m_state == 1) || (m_state == 2 && m_q.size() < DEPTH);
        chk({tag, ".reqIn"}, reqIn, exp_req);
        chk({tag, ".reqOut"}, reqOut, m_q.size() != 0);
        chk({tag, ".count"}, fifo_count, m_q.size());
        chk({tag, ".state"}, state, m_state);
        if (m_q.size() != 0) chk({tag, ".dataOut"}, dataOut, m_q[0]);
    endtask

    // Drive one cycle of inputs (called at a negedge), advance the model, check after the edge.
    task automatic cycle(input string tag, input logic [DW-1:0] di, input bit rdi, input bit pr,
                         input bit ro, input bit er, input int rot, input bit ch, input bit dc);
        bit exp_req, xfer, popv;
        logic [DW-1:0] o;
        int off;
        dataIn = di; rdyIn = rdi; prog = pr; rdyOut = ro; error = er;
        rot_offset = RW'(rot); chain_en = ch; decrypt = dc;
        exp_req = (m_state == 1) || (m_state == 2 && m_q.size() < DEPTH);
        if (er) begin
            m_q.delete();
            m_state = 0;
            m_key   = '0;
        end else begin
            xfer = exp_req && rdi;
            popv = (m_q.size() != 0) && ro;
            if (popv) void'(m_q.pop_front());
            if (m_state == 0) begin
                if (pr) m_state = 1;
            end else if (m_state == 1) begin
                if (xfer) begin
                    m_key = di; m_base = rot; m_n = 0; m_fb = '0;
                    m_chain = ch; m_dec = dc; m_state = 2;
                end
            end else begin
                if (xfer) begin
                    off = (m_base + m_n * STEP) % DW;
                    o   = di ^ rotl_ref(m_key, off) ^ (m_chain ? m_fb : {DW{1'b0}});
                    m_q.push_back(o);
                    if (m_chain) m_fb = m_dec ? di : o;
                    m_n = (m_n + 1) % DW;
                end
                if (pr) m_state = 1;
            end
        end
        @(negedge clk);
        check_outputs(tag);
    endtask

    task automatic rekey(input string tag, input logic [DW-1:0] k, input int rot, input bit ch, input bit dc);
        cycle({tag, ".prog"}, '0, 1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0);
        cycle({tag, ".key"}, k, 1'b1, 1'b0, 1'b1, 1'b0, rot, ch, dc);
    endtask

    task automatic send(input string tag, input logic [DW-1:0] d, input bit ro);
        cycle(tag, d, 1'b1, 1'b0, ro, 1'b0, 0, 1'b0, 1'b0);
    endtask

    task automatic idle(input string tag, input bit ro);
        cycle(tag, '0, 1'b0, 1'b0, ro, 1'b0, 0, 1'b0, 1'b0);
    endtask

    initial begin
        reset = 1'b1; dataIn = '0; rdyIn = 1'b0; rot_offset = '0; prog = 1'b0;
        chain_en = 1'b0; decrypt = 1'b0; error = 1'b0; rdyOut = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst.dataOut", dataOut, 32'h0);
        chk("rst.reqOut", reqOut, 1'b0);
        chk("rst.reqIn", reqIn, 1'b0);
        chk("rst.state", state, 2'd0);
        chk("rst.count", fifo_count, 3'd0);
        reset = 1'b0;

        // Plain rotation, offset starts at 0
        rekey("t1", 32'h8000_0001, 0, 1'b0, 1'b0);
        send("t1.w0", 32'h0, 1'b1);
        chk("t1.w0.const", dataOut, 32'h8000_0001);
        send("t1.w1", 32'h0, 1'b1);
        chk("t1.w1.const", dataOut, 32'h0000_0003);
        idle("t1.drain", 1'b1);
        chk("t1.state", state, 2'd2);

        // Offset wraps from 31 to 0
        rekey("t2", 32'h8000_0001, 31, 1'b0, 1'b0);
        send("t2.w0", 32'h0, 1'b1);
        chk("t2.w0.const", dataOut, 32'hC000_0000);
        send("t2.w1", 32'h0, 1'b1);
        chk("t2.w1.const", dataOut, 32'h8000_0001);
        idle("t2.drain", 1'b1);

        // Chained encrypt then chained decrypt
        rekey("t3e", 32'h0, 0, 1'b1, 1'b0);
        send("t3e.w0", 32'h1111_1111, 1'b1);
        chk("t3e.w0.const", dataOut, 32'h1111_1111);
        send("t3e.w1", 32'h2222_2222, 1'b1);
        chk("t3e.w1.const", dataOut, 32'h3333_3333);
        idle("t3e.drain", 1'b1);
        rekey("t3d", 32'h0, 0, 1'b1, 1'b1);
        send("t3d.w0", 32'h1111_1111, 1'b1);
        chk("t3d.w0.const", dataOut, 32'h1111_1111);
        send("t3d.w1", 32'h3333_3333, 1'b1);
        chk("t3d.w1.const", dataOut, 32'h2222_2222);
        idle("t3d.drain", 1'b1);

        // Fill the FIFO with the consumer stalled, then drain
        rekey("t4", 32'h0F0F_1234, 3, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) send("t4.fill", $urandom, 1'b0);
        chk("t4.full.reqIn", reqIn, 1'b0);
        chk("t4.full.count", fifo_count, 3'd4);
        send("t4.extra", 32'hDEAD_BEEF, 1'b0);
        chk("t4.extra.count", fifo_count, 3'd4);
        idle("t4.pop1", 1'b1);
        chk("t4.pop1.reqIn", reqIn, 1'b1);
        for (int i = 0; i < 3; i++) idle("t4.drain", 1'b1);
        chk("t4.empty.count", fifo_count, 3'd0);

        // Error flush with words buffered
        rekey("t5", 32'h1357_9BDF, 7, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) send("t5.fill", $urandom, 1'b0);
        cycle("t5.err", 32'hAAAA_5555, 1'b1, 1'b0, 1'b1, 1'b1, 0, 1'b0, 1'b0);
        chk("t5.err.count", fifo_count, 3'd0);
        chk("t5.err.reqOut", reqOut, 1'b0);
        chk("t5.err.state", state, 2'd0);
        send("t5.nokey", 32'h1234_5678, 1'b1);
        chk("t5.nokey.count", fifo_count, 3'd0);
        rekey("t5r", 32'h0, 0, 1'b0, 1'b0);
        send("t5r.w0", 32'h1234_5678, 1'b1);
        chk("t5r.w0.const", dataOut, 32'h1234_5678);
        idle("t5r.drain", 1'b1);

        // Randomized traffic with occasional re-key (incl. same-cycle data) and error
        rekey("rnd", $urandom, $urandom_range(0, 31), 1'(($urandom_range(0, 1))), 1'(($urandom_range(0, 1))));
        for (int i = 0; i < 400; i++) begin
            bit pr, er;
            pr = (m_state != 1) && ($urandom_range(0, 15) == 0);
            er = ($urandom_range(0, 79) == 0);
            cycle("rnd", $urandom, 1'($urandom_range(0, 3) != 0), pr, 1'($urandom_range(0, 2) != 0),
                  er, $urandom_range(0, 31), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // Asynchronous reset between edges with data buffered
        rekey("t6", 32'hCAFE_F00D, 5, 1'b1, 1'b0);
        send("t6.w0", 32'h0102_0304, 1'b0);
        send("t6.w1", 32'h0506_0708, 1'b0);
        #2 reset = 1'b1;
        #1;
        chk("t6.async.dataOut", dataOut, 32'h0);
        chk("t6.async.reqOut", reqOut, 1'b0);
        chk("t6.async.reqIn", reqIn, 1'b0);
        chk("t6.async.state", state, 2'd0);
        chk("t6.async.count", fifo_count, 3'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        idle("t6.after", 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
